// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings and handshake constants for the divider
package div_unit_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } div_state_t;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift left, trial subtract, set quotient bit)
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]  work,
  input  logic [DATA_W-1:0]  divisor,
  output logic [2*DATA_W:0]  work_next
);
  logic [2*DATA_W:0] shifted;
  logic [DATA_W:0]   diff;
  assign shifted = work << 1;
  assign diff = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
  // a set top bit of diff means the partial remainder was smaller than the divisor
  assign work_next = diff[DATA_W] ? shifted : {diff, shifted[DATA_W-1:1], 1'b1};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider returning {remainder, quotient}
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  div_state_t        state;
  logic [CW-1:0]     cnt;
  logic [2*DATA_W:0] work, work_next;
  logic [DATA_W-1:0] divisor, op1_abs, op2_abs, quo, rem;
  logic              qsign, rsign, op1_neg, op2_neg;
  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;
  assign quo = work_next[DATA_W-1:0];
  assign rem = work_next[2*DATA_W-1:DATA_W];
  div_step #(.DATA_W(DATA_W)) u_step (
    .work      (work),
    .divisor   (divisor),
    .work_next (work_next)
  );
  // control FSM: operand capture, iteration count, sign fix-up and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      qsign    <= 1'b0;
      rsign    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        IDLE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state   <= RUN;
              cnt     <= '0;
              work    <= {{(DATA_W+1){1'b0}}, op1_abs};
              divisor <= op2_abs;
              qsign   <= op1_neg ^ op2_neg;
              rsign   <= op1_neg;
            end
          end
        end
        BYZERO: begin
          state    <= annul_i ? IDLE : DONE;
          result_o <= '0;
          ready_o  <= annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
        end
        RUN: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            work <= work_next;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              state    <= DONE;
              result_o <= {rsign ? -rem : rem, qsign ? -quo : quo};
              ready_o  <= DIV_RESULT_READY;
            end
          end
        end
        DONE: begin
          if (start_i == DIV_STOP) begin
            state    <= IDLE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed vectors
module tb_div_unit;
  typedef struct {
    logic [63:0] res;
    int          lat;
    string       name;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          issue = 0;
  logic        prev_ready = 1'b0;
  logic [63:0] last_res = '0;
  string       last_name = "";

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compares on ready rise, checks hold stability and the clear on ready fall
  always @(negedge clk) begin
    if (!rst) begin
      if (ready && !prev_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ready: result=%h with no division outstanding", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          last_res  = e.res;
          last_name = e.name;
          if (result !== e.res || cyc - issue != e.lat) begin
            miscompares++;
            $display("FAIL %s: got %h after %0d edges, expected %h after %0d edges",
                     e.name, result, cyc - issue, e.res, e.lat);
          end
        end
      end else if (ready && prev_ready) begin
        vectors++;
        if (result !== last_res) begin
          miscompares++;
          $display("FAIL %s_hold: got %h, expected %h", last_name, result, last_res);
        end
      end else if (!ready && prev_ready) begin
        vectors++;
        if (result !== 64'h0) begin
          miscompares++;
          $display("FAIL %s_clear: got %h, expected 0", last_name, result);
        end
      end
    end
    prev_ready = ready;
  end

  task automatic push(input string name, input logic [31:0] q, input logic [31:0] r, input int lat);
    exp_t e;
    e.res  = {r, q};
    e.lat  = lat;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string name, input int hold, input bit scramble);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
      if (scramble) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~signed_div;
      end
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: ready=%b, expected 1 within 100 cycles", name, ready);
    end
    repeat (hold) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic div(input string name, input bit sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input int lat,
                     input int hold, input bit scramble);
    push(name, q, r, lat);
    signed_div = sg;
    op1 = a;
    op2 = b;
    start = 1'b1;
    issue = cyc + 1;
    @(negedge clk);
    wait_ready(name, hold, scramble);
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      miscompares++;
      $display("FAIL %s: ready=%b result=%h, expected ready=0 result=0", name, ready, result);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 32, 5, 1'b0);
    div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32, 0, 1'b0);
    div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 32, 0, 1'b0);
    div("div_5_0", 1'b1, 32'd5, 32'd0, 32'h0, 32'h0, 1, 2, 1'b0);
    div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32, 0, 1'b0);
    div("divu_ff_10", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 32, 0, 1'b0);
    // annul: start a division, kill it after nine iterations, ready must never rise
    signed_div = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    repeat (40) @(negedge clk);
    check_idle("annul_no_result");
    div("divu_ff_3", 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'h0, 32, 0, 1'b0);
    div("div_scramble", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 32, 1, 1'b1);
    // reset at iteration 20 with start held: outputs clear, then a full restart
    signed_div = 1'b0;
    op1 = 32'd1234;
    op2 = 32'd10;
    start = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_run");
    rst = 1'b0;
    push("divu_restart", 32'd123, 32'd4, 32);
    issue = cyc + 1;
    @(negedge clk);
    wait_ready("divu_restart", 0, 1'b0);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
